// File: rtl/ej3_w_serial_tx.sv
// Serial W-bit transmitter for the ej3 Moore FSM. It sends a parallel pattern MSB first,
// then idles for GAP cycles, and keeps a count of adjacent 1-1 bit pairs in the frame.
module ej3_w_serial_tx #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   output logic             ready,
   output logic             W,
   output logic             valid,
   output logic             done,
   output logic [CNT_W-1:0] pair_cnt
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             w_q, w_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] pair_q, pair_d;

   // Reset is synchronous and active-high even though the port is named reset_n.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         w_q     <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         pair_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         w_q     <= w_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         pair_q  <= pair_d;
      end
   end

   // shift_q holds the bits still to be sent, left-aligned. w_q doubles as the previous
   // bit, which is what the pair count compares against.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      w_d     = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      pair_d  = pair_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_SHIFT;
               shift_d = {data[WIDTH-2:0], 1'b0};
               idx_d   = '0;
               pair_d  = '0;
               w_d     = data[WIDTH-1];
               valid_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               gap_d   = '0;
               state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            end else begin
               w_d     = shift_q[WIDTH-1];
               valid_d = 1'b1;
               shift_d = shift_q << 1;
               idx_d   = idx_q + IDX_W'(1);
               if (w_q && shift_q[WIDTH-1]) begin
                  pair_d = pair_q + CNT_W'(1);
               end
            end
         end
         ST_GAP: begin
            if (gap_q == LAST_GAP) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ready    = (state_q == ST_IDLE);
   assign W        = w_q;
   assign valid    = valid_q;
   assign done     = done_q;
   assign pair_cnt = pair_q;

endmodule

// File: tb/tb_ej3_w_serial_tx.sv
// Bench for ej3_w_serial_tx: a GAP=1 instance and a GAP=0 instance, checked cycle by cycle
// against expected bits and pair counts worked out from the frame pattern itself.
module tb_ej3_w_serial_tx;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             load, load0;
   logic [WIDTH-1:0] data, data0;
   logic             ready, W, valid, done;
   logic             ready0, w0, valid0, done0;
   logic [CNT_W-1:0] pair_cnt, pair_cnt0;

   int vectors = 0;
   int miscompares = 0;

   ej3_w_serial_tx #(.WIDTH(WIDTH), .GAP(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .data(data),
      .ready(ready), .W(W), .valid(valid), .done(done), .pair_cnt(pair_cnt)
   );

   ej3_w_serial_tx #(.WIDTH(WIDTH), .GAP(0), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .reset_n(reset_n), .load(load0), .data(data0),
      .ready(ready0), .W(w0), .valid(valid0), .done(done0), .pair_cnt(pair_cnt0)
   );

   always #5 clk = ~clk;

   // Bit k of a frame is data[WIDTH-1-k]; pairs are counted over bits 1..k.
   function automatic logic exp_bit(input logic [WIDTH-1:0] d, input int k);
      return d[WIDTH-1-k];
   endfunction

   function automatic int exp_pairs(input logic [WIDTH-1:0] d, input int k);
      int n = 0;
      for (int j = 1; j <= k; j++) begin
         if (d[WIDTH-1-j] && d[WIDTH-j]) n++;
      end
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic l, input logic [WIDTH-1:0] d);
      load = l;
      data = d;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_ready"}, ready, 1);
      checkOutput({tag, "_w"}, W, 0);
      checkOutput({tag, "_valid"}, valid, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_pair"}, pair_cnt, 0);
   endtask

   // One frame on the GAP=1 instance; optional ignored load at bit busy_at, optional reset at bit abort_at.
   task automatic sendFrame(input logic [WIDTH-1:0] d, input int busy_at,
                            input logic [WIDTH-1:0] busy_d, input int abort_at);
      int n = 0;
      while (ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("ready_wait", ready, 1);
      applyStimulus(1'b1, d);
      tick();
      applyStimulus(1'b0, 8'($urandom));
      for (int k = 0; k < WIDTH; k++) begin
         checkOutput("bit_w", W, exp_bit(d, k));
         checkOutput("bit_valid", valid, 1);
         checkOutput("bit_ready", ready, 0);
         checkOutput("bit_done", done, 0);
         checkOutput("bit_pair", pair_cnt, exp_pairs(d, k));
         if (k == abort_at) begin
            reset_n = 1'b1;
            tick();
            checkIdle("abort");
            reset_n = 1'b0;
            for (int c = 0; c < WIDTH + 3; c++) begin
               tick();
               checkOutput("abort_no_done", done, 0);
               checkOutput("abort_no_valid", valid, 0);
            end
            return;
         end
         if (k == busy_at) applyStimulus(1'b1, busy_d);
         else applyStimulus(1'b0, 8'($urandom));
         tick();
      end
      applyStimulus(1'b0, 8'($urandom));
      checkOutput("done_pulse", done, 1);
      checkOutput("done_w", W, 0);
      checkOutput("done_valid", valid, 0);
      checkOutput("done_ready", ready, 0);
      checkOutput("done_pair", pair_cnt, exp_pairs(d, WIDTH-1));
      tick();
      checkOutput("post_ready", ready, 1);
      checkOutput("post_done", done, 0);
      checkOutput("post_valid", valid, 0);
      checkOutput("post_pair", pair_cnt, exp_pairs(d, WIDTH-1));
      tick();
      checkOutput("idle_valid", valid, 0);
      checkOutput("idle_ready", ready, 1);
   endtask

   task automatic checkBits0(input logic [WIDTH-1:0] d);
      for (int k = 0; k < WIDTH; k++) begin
         checkOutput("g0_w", w0, exp_bit(d, k));
         checkOutput("g0_valid", valid0, 1);
         checkOutput("g0_ready", ready0, 0);
         checkOutput("g0_done", done0, 0);
         checkOutput("g0_pair", pair_cnt0, exp_pairs(d, k));
         tick();
      end
      checkOutput("g0_done_pulse", done0, 1);
      checkOutput("g0_done_w", w0, 0);
      checkOutput("g0_done_valid", valid0, 0);
      checkOutput("g0_done_ready", ready0, 1);
      checkOutput("g0_done_pair", pair_cnt0, exp_pairs(d, WIDTH-1));
   endtask

   // Two frames on the GAP=0 instance, the second load asserted in the first frame's done cycle.
   task automatic sendChain0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int n = 0;
      while (ready0 !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("g0_ready_wait", ready0, 1);
      load0 = 1'b1;
      data0 = a;
      tick();
      load0 = 1'b0;
      data0 = 8'($urandom);
      checkBits0(a);
      load0 = 1'b1;
      data0 = b;
      tick();
      load0 = 1'b0;
      data0 = 8'($urandom);
      checkBits0(b);
      tick();
      checkOutput("g0_post_done", done0, 0);
      checkOutput("g0_post_valid", valid0, 0);
      checkOutput("g0_post_pair", pair_cnt0, exp_pairs(b, WIDTH-1));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n = 1'b1;
      applyStimulus(1'b1, 8'hFF);
      load0 = 1'b1;
      data0 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkIdle("reset");
         checkOutput("reset_g0_ready", ready0, 1);
         checkOutput("reset_g0_valid", valid0, 0);
      end
      reset_n = 1'b0;
      applyStimulus(1'b0, 8'h00);
      load0 = 1'b0;
      tick();
      checkIdle("released");

      sendFrame(8'b1011_0110, -1, 8'h00, -1);
      sendFrame(8'hFF, -1, 8'h00, -1);
      sendFrame(8'h00, -1, 8'h00, -1);
      sendFrame(8'hA5, 2, 8'h3C, -1);
      sendFrame(8'hFF, -1, 8'h00, 4);
      sendChain0(8'hC0, 8'h03);

      for (int r = 0; r < 6; r++) begin
         sendFrame(8'($urandom), int'($urandom_range(0, 9)), 8'($urandom), -1);
      end
      for (int r = 0; r < 3; r++) begin
         sendChain0(8'($urandom), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ej3_w_serial_tx.md
Name: ej3_w_serial_tx

Overview:
- Serial transmitter for the ej3 Moore FSM's single-bit input W.
- Accepts a parallel WIDTH-bit pattern via a load/ready handshake and drives it out one bit per clk, MSB first.
- Inserts GAP idle cycles (W=0) after each frame.
- Reports a reference count of consecutive-1 pairs in the frame, which checks the detector's Zout activity.

Parameters:
- WIDTH, 8, bits per frame (>=2).
- GAP, 1, idle cycles with W=0 after each frame before ready returns (>=0).
- CNT_W, 4, width of pair_cnt; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset. Active-HIGH despite the name: a 1 sampled on a clk edge resets.
- load  input  1  frame request, qualified by ready.
- data  input  WIDTH  pattern; sampled only on an accepted load.
- ready  output  1  1 when IDLE; a load is accepted on an edge where load=1 and ready=1.
- W  output  1  registered serial bit to the FSM.
- valid  output  1  1 while W carries a frame bit.
- done  output  1  registered one-cycle pulse after the last bit.
- pair_cnt  output  CNT_W  number of frame bit positions i>0 where bit i = 1 and bit i-1 = 1.

Behaviour:
- Reset (reset_n=1 at an edge):
  - Next state is IDLE; W=0, valid=0, done=0, pair_cnt=0, shift register and bit counter cleared.
  - Reset has priority over load and aborts any frame in progress; no done pulse is issued for an aborted frame.
  - ready=1 from the cycle after the reset edge.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ready=1, W=0, valid=0.
  - Accepted load: capture data, clear pair_cnt, set bit index=0, go to SHIFT.
  - W=data[WIDTH-1] and valid=1 in the cycle following the accept edge.
- SHIFT:
  - ready=0; one bit per cycle, MSB first; WIDTH cycles total.
  - Bit k (k=0..WIDTH-1) is presented in the k-th cycle after the accept edge (0-based).
  - pair_cnt increments in the cycle bit k is presented when k>0 and bits k and k-1 are both 1.
  - pair_cnt never wraps within a frame (guaranteed by CNT_W).
  - After the last bit:
    - GAP>0: go to GAP.
    - GAP=0: go to IDLE.
- GAP: ready=0, W=0, valid=0 for exactly GAP cycles, then go to IDLE.
- done:
  - 1 for exactly the single cycle following the last-bit cycle. That cycle is either the first GAP cycle or the first IDLE cycle when GAP=0.
  - With GAP=0, a load asserted in the done cycle is accepted, giving back-to-back frames separated by one W=0 cycle.
- Load while ready=0 is ignored: no effect on the current frame, data is not captured, and the request is not queued.
- pair_cnt holds its final value through GAP and IDLE until the next accepted load or reset.
- Latency: accept edge to first bit = 1 cycle; accept edge to done = WIDTH+1 cycles; accept edge to ready = WIDTH+GAP+1 cycles.
- Data changes after the accept edge have no effect on the frame in flight.

Test Plan:
- Reset with load=1 held → cycle after reset edge: ready=1, W=0, valid=0, done=0, pair_cnt=0; no frame starts until reset=0.
- WIDTH=8, GAP=1, data=8'b1011_0110 accepted at edge E0:
  - W = 1,0,1,1,0,1,1,0 in cycles E0+1..E0+8 with valid=1.
  - done=1 and W=0 in cycle E0+9; ready=1 at E0+10; pair_cnt=2.
- data=8'hFF → W=1 for 8 cycles, pair_cnt=7.
- data=8'h00 → W=0 throughout, valid=1 for 8 cycles, pair_cnt=0, done pulses once.
- Busy load: accept 8'hA5, then pulse load with data=8'h3C during the 3rd bit → output still 1,0,1,0,0,1,0,1; single done; pair_cnt=0.
- Mid-frame reset: reset during bit 4 of 8'hFF → next cycle W=0, valid=0, ready=1, pair_cnt=0, and done never asserts.
- GAP=0 back-to-back: 8'hC0 then 8'h03, with the second load asserted in the done cycle → second frame's first bit follows with a single W=0 cycle between frames; pair_cnt=1 after each frame.
